// File: rtl/mem_port_arb_if.sv
// Request/response bundle between the fill-buffer requesters (ic, dc), the arbiter
// and the next-level memory port.
interface mem_port_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 512
);
  logic              ic_req_valid;
  logic              ic_req_ready;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              dc_req_valid;
  logic              dc_req_ready;
  logic [ADDR_W-1:0] dc_req_addr;
  logic              dc_req_wr;
  logic [DATA_W-1:0] dc_req_data;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_wr;
  logic [DATA_W-1:0] mem_req_data;
  logic              mem_req_src;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              ic_rsp_valid;
  logic [DATA_W-1:0] ic_rsp_data;
  logic              dc_rsp_valid;
  logic [DATA_W-1:0] dc_rsp_data;

  // Arbiter view.
  modport master (
    input  ic_req_valid, ic_req_addr,
    input  dc_req_valid, dc_req_addr, dc_req_wr, dc_req_data,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output ic_req_ready, dc_req_ready,
    output mem_req_valid, mem_req_addr, mem_req_wr, mem_req_data, mem_req_src,
    output ic_rsp_valid, ic_rsp_data, dc_rsp_valid, dc_rsp_data
  );

  // Environment view: requesters plus memory.
  modport slave (
    output ic_req_valid, ic_req_addr,
    output dc_req_valid, dc_req_addr, dc_req_wr, dc_req_data,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  ic_req_ready, dc_req_ready,
    input  mem_req_valid, mem_req_addr, mem_req_wr, mem_req_data, mem_req_src,
    input  ic_rsp_valid, ic_rsp_data, dc_rsp_valid, dc_rsp_data
  );
endinterface

// File: rtl/mem_port_arb.sv
// Round-robin arbiter for the shared memory port between instruction fetch (ic) and
// data (dc) miss paths; an in-order source FIFO steers each response back.
module mem_port_arb #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 512,
  parameter int MAX_OUT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  mem_port_arb_if.master           bus,
  output logic [$clog2(MAX_OUT):0] outstanding,
  output logic                     rsp_err
);
  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

  logic              req_vld_q, req_vld_d;
  logic [ADDR_W-1:0] req_addr_q;
  logic              req_wr_q;
  logic [DATA_W-1:0] req_data_q;
  logic              req_src_q;
  logic              prio_q, prio_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic              src_fifo_q [MAX_OUT];
  logic              ic_rsp_vld_q, dc_rsp_vld_q, err_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic reg_free, can_grant, grant_ic, grant_dc, push, pop, head_src;

  // Grant uses the current count only: a response popping this cycle does not
  // free a slot until the next edge.
  always_comb begin
    reg_free  = !req_vld_q || bus.mem_req_ready;
    can_grant = reset && reg_free && (cnt_q < CNT_MAX);
    grant_ic  = can_grant && bus.ic_req_valid && (!bus.dc_req_valid || !prio_q);
    grant_dc  = can_grant && bus.dc_req_valid && (!bus.ic_req_valid || prio_q);
    push      = grant_ic || grant_dc;
    pop       = bus.mem_rsp_valid && (cnt_q != '0);
    head_src  = src_fifo_q[rd_ptr_q];

    prio_d = prio_q;
    if (grant_ic)      prio_d = 1'b1;
    else if (grant_dc) prio_d = 1'b0;

    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    req_vld_d = req_vld_q;
    if (push)                   req_vld_d = 1'b1;
    else if (bus.mem_req_ready) req_vld_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_vld_q    <= 1'b0;
      prio_q       <= 1'b0;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ic_rsp_vld_q <= 1'b0;
      dc_rsp_vld_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      req_vld_q    <= req_vld_d;
      prio_q       <= prio_d;
      cnt_q        <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      ic_rsp_vld_q <= pop && !head_src;
      dc_rsp_vld_q <= pop && head_src;
      if (bus.mem_rsp_valid && (cnt_q == '0)) err_q <= 1'b1;
    end
  end

  // Payload storage carries no reset; validity is tracked by the registers above.
  always_ff @(posedge clk) begin
    if (push) begin
      req_addr_q           <= grant_dc ? bus.dc_req_addr : bus.ic_req_addr;
      req_wr_q             <= grant_dc && bus.dc_req_wr;
      req_data_q           <= grant_dc ? bus.dc_req_data : '0;
      req_src_q            <= grant_dc;
      src_fifo_q[wr_ptr_q] <= grant_dc;
    end
    if (pop) rsp_data_q <= bus.mem_rsp_data;
  end

  assign bus.ic_req_ready  = grant_ic;
  assign bus.dc_req_ready  = grant_dc;
  assign bus.mem_req_valid = req_vld_q;
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.mem_req_wr    = req_wr_q;
  assign bus.mem_req_data  = req_data_q;
  assign bus.mem_req_src   = req_src_q;
  assign bus.ic_rsp_valid  = ic_rsp_vld_q;
  assign bus.ic_rsp_data   = rsp_data_q;
  assign bus.dc_rsp_valid  = dc_rsp_vld_q;
  assign bus.dc_rsp_data   = rsp_data_q;
  assign outstanding       = cnt_q;
  assign rsp_err           = err_q;
endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: arbitration order, backpressure, outstanding
// limit, response routing, protocol error flag and asynchronous reset.
module tb_mem_port_arb;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 512;
  localparam int MAX_OUT = 4;
  localparam int CW      = $clog2(MAX_OUT) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [CW-1:0] outstanding;
  logic          rsp_err;
  int            errors = 0;
  int            checks = 0;

  mem_port_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .reset(reset), .bus(bus), .outstanding(outstanding), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkc(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [ADDR_W-1:0] obs, input logic [ADDR_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rsp(input logic [DATA_W-1:0] d);
    bus.mem_rsp_data  = d;
    bus.mem_rsp_valid = 1'b1;
    tick();
    bus.mem_rsp_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  function automatic logic [DATA_W-1:0] pat(input logic [31:0] seed);
    return {16{seed}};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic e;
    bus.ic_req_valid  = 1'b1;
    bus.ic_req_addr   = '0;
    bus.dc_req_valid  = 1'b0;
    bus.dc_req_addr   = '0;
    bus.dc_req_wr     = 1'b0;
    bus.dc_req_data   = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    #3;
    chk1("rst_ic_ready", bus.ic_req_ready, 1'b0);
    chk1("rst_mem_vld", bus.mem_req_valid, 1'b0);
    chkc("rst_outstanding", outstanding, 3'd0);
    chk1("rst_err", rsp_err, 1'b0);
    bus.ic_req_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;

    // ic only, three back-to-back requests
    bus.mem_req_ready = 1'b1;
    bus.ic_req_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.ic_req_addr = 32'h100 + 32'(k * 'h40);
      #1;
      chk1("t1_ic_ready", bus.ic_req_ready, 1'b1);
      tick();
      chk1("t1_mem_vld", bus.mem_req_valid, 1'b1);
      chka("t1_mem_addr", bus.mem_req_addr, 32'h100 + 32'(k * 'h40));
      chk1("t1_src", bus.mem_req_src, 1'b0);
      chk1("t1_wr", bus.mem_req_wr, 1'b0);
      chkc("t1_outstanding", outstanding, CW'(k + 1));
    end
    bus.ic_req_valid = 1'b0;
    tick();
    chk1("t1_mem_vld_drop", bus.mem_req_valid, 1'b0);
    chkc("t1_out_hold", outstanding, 3'd3);
    for (int k = 0; k < 3; k++) begin
      rsp(pat(32'hA5A50000 + 32'(k)));
      chk1("t1_ic_rsp_vld", bus.ic_rsp_valid, 1'b1);
      chk1("t1_dc_rsp_vld", bus.dc_rsp_valid, 1'b0);
      chkd("t1_ic_rsp_data", bus.ic_rsp_data, pat(32'hA5A50000 + 32'(k)));
      chkc("t1_out_drain", outstanding, CW'(2 - k));
    end
    tick();
    chk1("t1_ic_rsp_pulse", bus.ic_rsp_valid, 1'b0);

    // both requesters valid: alternating grants starting with ic
    do_reset();
    bus.ic_req_valid = 1'b1;
    bus.ic_req_addr  = 32'h200;
    bus.dc_req_valid = 1'b1;
    bus.dc_req_addr  = 32'h300;
    bus.dc_req_wr    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e = (k % 2 == 0);
      #1;
      chk1("t2_ic_ready", bus.ic_req_ready, e);
      chk1("t2_dc_ready", bus.dc_req_ready, !e);
      chk1("t2_not_both", bus.ic_req_ready & bus.dc_req_ready, 1'b0);
      tick();
      chk1("t2_src", bus.mem_req_src, !e);
      chkc("t2_outstanding", outstanding, CW'(k + 1));
    end

    // FIFO full: fifth request stalls; a same-cycle response does not bypass
    bus.dc_req_valid = 1'b0;
    #1;
    chk1("t4_full_stall", bus.ic_req_ready, 1'b0);
    tick();
    chkc("t4_out_full", outstanding, 3'd4);
    bus.mem_rsp_data  = pat(32'h11110000);
    bus.mem_rsp_valid = 1'b1;
    #1;
    chk1("t4_no_bypass", bus.ic_req_ready, 1'b0);
    tick();
    bus.mem_rsp_valid = 1'b0;
    chkc("t4_out_pop", outstanding, 3'd3);
    chk1("t4_ic_rsp", bus.ic_rsp_valid, 1'b1);
    #1;
    chk1("t4_grant_next", bus.ic_req_ready, 1'b1);
    tick();
    chkc("t4_out_refill", outstanding, 3'd4);
    chk1("t4_src", bus.mem_req_src, 1'b0);
    bus.ic_req_valid = 1'b0;
    // FIFO now holds dc, ic, dc, ic
    for (int k = 0; k < 4; k++) begin
      e = (k % 2 == 0);
      rsp(pat(32'hD0D00000 + 32'(k)));
      chk1("t5_dc_rsp_vld", bus.dc_rsp_valid, e);
      chk1("t5_ic_rsp_vld", bus.ic_rsp_valid, !e);
      chkd("t5_rsp_data", e ? bus.dc_rsp_data : bus.ic_rsp_data, pat(32'hD0D00000 + 32'(k)));
    end
    chkc("t5_out_empty", outstanding, 3'd0);

    // memory backpressure with a pending dc write (priority is dc here)
    bus.mem_req_ready = 1'b0;
    bus.dc_req_valid  = 1'b1;
    bus.dc_req_addr   = 32'h1000;
    bus.dc_req_wr     = 1'b1;
    bus.dc_req_data   = pat(32'hCAFEF00D);
    #1;
    chk1("t3_dc_ready", bus.dc_req_ready, 1'b1);
    tick();
    chk1("t3_mem_vld", bus.mem_req_valid, 1'b1);
    bus.dc_req_addr  = 32'h2000;
    bus.dc_req_data  = pat(32'h0BADBEEF);
    bus.ic_req_valid = 1'b1;
    bus.ic_req_addr  = 32'h3000;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk1("t3_ic_ready_hold", bus.ic_req_ready, 1'b0);
      chk1("t3_dc_ready_hold", bus.dc_req_ready, 1'b0);
      chka("t3_addr_stable", bus.mem_req_addr, 32'h1000);
      chk1("t3_wr_stable", bus.mem_req_wr, 1'b1);
      chkd("t3_data_stable", bus.mem_req_data, pat(32'hCAFEF00D));
      tick();
    end
    bus.mem_req_ready = 1'b1;
    #1;
    chk1("t3_ic_wins", bus.ic_req_ready, 1'b1);
    chk1("t3_dc_loses", bus.dc_req_ready, 1'b0);
    tick();
    bus.ic_req_valid = 1'b0;
    bus.dc_req_valid = 1'b0;
    chka("t3_ic_addr", bus.mem_req_addr, 32'h3000);
    chk1("t3_ic_wr", bus.mem_req_wr, 1'b0);
    chkd("t3_ic_data", bus.mem_req_data, '0);
    chkc("t3_outstanding", outstanding, 3'd2);
    tick();
    chk1("t3_mem_vld_drop", bus.mem_req_valid, 1'b0);
    rsp(pat(32'h0000AC01));
    chk1("t3_dc_ack", bus.dc_rsp_valid, 1'b1);
    rsp(pat(32'h0000AC02));
    chk1("t3_ic_rsp", bus.ic_rsp_valid, 1'b1);
    chkc("t3_out_empty", outstanding, 3'd0);

    // response with nothing outstanding
    rsp(pat(32'hDEAD0000));
    chk1("t6_err_set", rsp_err, 1'b1);
    chk1("t6_no_ic_rsp", bus.ic_rsp_valid, 1'b0);
    chk1("t6_no_dc_rsp", bus.dc_rsp_valid, 1'b0);
    chkc("t6_out_zero", outstanding, 3'd0);
    tick();
    chk1("t6_err_sticky", rsp_err, 1'b1);

    // asynchronous reset in the middle of traffic
    bus.mem_req_ready = 1'b0;
    bus.ic_req_valid  = 1'b1;
    bus.ic_req_addr   = 32'h4000;
    tick();
    chk1("t7_mem_vld_pre", bus.mem_req_valid, 1'b1);
    chkc("t7_out_pre", outstanding, 3'd1);
    #1;
    reset = 1'b0;
    #1;
    chk1("t7_mem_vld", bus.mem_req_valid, 1'b0);
    chkc("t7_outstanding", outstanding, 3'd0);
    chk1("t7_err", rsp_err, 1'b0);
    chk1("t7_ic_ready", bus.ic_req_ready, 1'b0);
    chk1("t7_ic_rsp", bus.ic_rsp_valid, 1'b0);
    bus.ic_req_valid = 1'b0;
    tick();
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arb.md
Name: mem_port_arb

Overview:
- Arbitrates the single shared memory-side port between the instruction-fetch miss path (ic) and the data miss/writeback path (dc).
- Sits between the icache/mem-unit fill buffers and the next-level memory.
- Issues one registered request per cycle using round-robin priority.
- Tracks outstanding requests in an in-order source FIFO and routes each response back to its requester.

Parameters:
- ADDR_W, 32, request address width.
- DATA_W, 512, cache-line data width for write requests and read responses.
- MAX_OUT, 4, maximum requests outstanding at memory (power of two, >=2).

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- ic_req_valid  in  1  fetch-side request valid.
- ic_req_ready  out  1  fetch-side request accepted this cycle.
- ic_req_addr  in  ADDR_W  fetch line address.
- dc_req_valid  in  1  data-side request valid.
- dc_req_ready  out  1  data-side request accepted this cycle.
- dc_req_addr  in  ADDR_W  data line address.
- dc_req_wr  in  1  data request is a line write.
- dc_req_data  in  DATA_W  write data.
- mem_req_valid  out  1  request to memory valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDR_W  request address.
- mem_req_wr  out  1  write request.
- mem_req_data  out  DATA_W  write data.
- mem_req_src  out  1  requester: 0=ic, 1=dc.
- mem_rsp_valid  in  1  response valid. Responses are in request order, exactly one per request; writes receive an ack.
- mem_rsp_data  in  DATA_W  response data.
- ic_rsp_valid  out  1  response to fetch side.
- ic_rsp_data  out  DATA_W  response data to fetch side.
- dc_rsp_valid  out  1  response to data side.
- dc_rsp_data  out  DATA_W  response data to data side.
- outstanding  out  $clog2(MAX_OUT)+1  requests granted and not yet responded.
- rsp_err  out  1  sticky protocol error flag.

Behaviour:
- Reset (asynchronous, active-low): all valid outputs 0, ready outputs 0, outstanding=0, FIFO empty, priority=ic, rsp_err=0. Data/address registers are don't-care.
- Output register:
  - Holds one request. It is free when !mem_req_valid, or when mem_req_valid & mem_req_ready in the current cycle.
  - Contents are stable while mem_req_valid & !mem_req_ready.
- Grant condition:
  - Requires the output register to be free this cycle and outstanding < MAX_OUT, using the current-cycle count with no bypass of a same-cycle response.
  - If one requester is valid, it wins. If both are valid, the priority holder wins.
- Ready signals:
  - ic_req_ready and dc_req_ready are combinational, equal to the grant, and at most one is high per cycle.
  - Requester values may depend on ready; neither ready depends on the other requester's valid beyond the arbitration above.
- On grant:
  - Load the output register next edge: addr, wr (forced 0 for ic), data (0 for ic), src.
  - Push src into the FIFO.
  - Priority flips to the non-granted requester. Priority is unchanged when there is no grant.
- Outstanding counts at grant, not at memory accept. Push without pop: +1. Pop without push: -1. Both in one cycle: unchanged.
- Response handling:
  - mem_rsp_valid pops the FIFO head.
  - Next cycle, asserts ic_rsp_valid or dc_rsp_valid (per the popped src) for exactly one cycle, with the data registered.
  - Response latency is 1 cycle; the requester has no backpressure.
- mem_rsp_valid with an empty FIFO: set rsp_err (sticky until reset), assert no rsp output, leave the count at 0.
- FIFO: circular with rd/wr pointers of $clog2(MAX_OUT) bits that wrap. Full = count==MAX_OUT and blocks grants.
- Reset mid-operation drops all in-flight tracking. Memory is reset concurrently.

Test Plan:
- ic only, 3 back-to-back reqs with mem_req_ready=1 → grants on cycles 0,1,2; mem_req_valid cycles 1–3, src=0; outstanding reaches 3.
- ic and dc both valid for 4 cycles, mem_req_ready=1 → grant order ic,dc,ic,dc; never both ready high.
- Hold mem_req_ready=0 for 5 cycles with a pending dc write addr 0x1000 → mem_req_addr/data/wr stable; no further grants; ready outputs 0.
- Issue 4 requests, no responses → outstanding=4 and the 5th request is stalled. Then pulse mem_rsp_valid in the same cycle the 5th is offered → no grant that cycle; grant next cycle; count stays 4.
- Sequence ic,dc,dc granted; responses D0,D1,D2 → ic_rsp_valid with D0, then dc_rsp_valid with D1, then D2, each 1 cycle after mem_rsp_valid.
- mem_rsp_valid after reset with nothing issued → rsp_err=1 and stays 1. Assert reset low mid-traffic → all valids 0, outstanding=0, rsp_err=0 immediately, without waiting for a clock edge.
